// File: rtl/pc_sequencer_if.sv
// Fetch-stage program-counter bus: control-side next-PC select in, and
// current PC, PC+4 and return-address stack status out.
interface pc_sequencer_if #(
  parameter int WIDTH     = 64,
  parameter int RAS_DEPTH = 8
);
  logic                         stall;
  logic [2:0]                   PS;
  logic [WIDTH-1:0]             in;
  logic [WIDTH-1:0]             PC;
  logic [WIDTH-1:0]             PC4;
  logic [WIDTH-1:0]             ras_top;
  logic [$clog2(RAS_DEPTH):0]   ras_count;
  logic                         ras_overflow;
  logic                         ras_underflow;

  modport master (
    output stall, PS, in,
    input  PC, PC4, ras_top, ras_count, ras_overflow, ras_underflow
  );

  modport slave (
    input  stall, PS, in,
    output PC, PC4, ras_top, ras_count, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with hold/increment/jump/branch, call/return via
// a circular return-address stack, stall, and restart to a reset vector.
module pc_sequencer #(
  parameter int               WIDTH        = 64,
  parameter int               RAS_DEPTH    = 8,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic          clock,
  input  logic          reset,
  pc_sequencer_if.slave bus
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  typedef enum logic [2:0] {
    PS_HOLD     = 3'b000,
    PS_INC      = 3'b001,
    PS_JUMP     = 3'b010,
    PS_BRANCH   = 3'b011,
    PS_CALL_ABS = 3'b100,
    PS_CALL_REL = 3'b101,
    PS_RETURN   = 3'b110,
    PS_RESTART  = 3'b111
  } ps_e;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] ras_mem_q [RAS_DEPTH];

  logic             mem_we;
  logic [PTR_W-1:0] mem_waddr;
  logic [WIDTH-1:0] mem_wdata;

  logic [WIDTH-1:0] pc4;
  logic [WIDTH-1:0] ofs;
  logic [WIDTH-1:0] rel_target;
  logic [WIDTH-1:0] top_entry;
  logic [PTR_W-1:0] ptr_inc;
  logic [PTR_W-1:0] ptr_dec;
  logic             stack_full;
  logic             stack_empty;

  assign pc4         = pc_q + WIDTH'(4);
  assign ofs         = {bus.in[WIDTH-3:0], 2'b00};
  assign rel_target  = pc4 + ofs;
  assign top_entry   = ras_mem_q[ptr_q];
  assign ptr_inc     = ptr_q + PTR_W'(1);
  assign ptr_dec     = ptr_q - PTR_W'(1);
  assign stack_full  = (cnt_q == CNT_FULL);
  assign stack_empty = (cnt_q == '0);

  always_comb begin
    pc_d      = pc_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    ovf_d     = 1'b0;
    unf_d     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = ptr_inc;
    mem_wdata = pc4;

    if (!bus.stall) begin
      unique case (ps_e'(bus.PS))
        PS_HOLD:   pc_d = pc_q;
        PS_INC:    pc_d = pc4;
        PS_JUMP:   pc_d = bus.in;
        PS_BRANCH: pc_d = rel_target;
        PS_CALL_ABS, PS_CALL_REL: begin
          pc_d   = (bus.PS == PS_CALL_ABS) ? bus.in : rel_target;
          mem_we = 1'b1;
          ptr_d  = ptr_inc;
          // A full stack wraps onto the oldest entry instead of growing.
          if (stack_full) ovf_d = 1'b1;
          else            cnt_d = cnt_q + CNT_W'(1);
        end
        PS_RETURN: begin
          if (stack_empty) begin
            pc_d  = pc4;
            unf_d = 1'b1;
          end else begin
            pc_d  = top_entry;
            ptr_d = ptr_dec;
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        PS_RESTART: begin
          pc_d  = RESET_VECTOR;
          ptr_d = '0;
          cnt_d = '0;
        end
        default: pc_d = pc_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q  <= RESET_VECTOR;
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Stack storage is deliberately not cleared by reset; count gates visibility.
  always_ff @(posedge clock) begin
    if (!reset && mem_we) ras_mem_q[mem_waddr] <= mem_wdata;
  end

  assign bus.PC            = pc_q;
  assign bus.PC4           = pc4;
  assign bus.ras_top       = stack_empty ? '0 : top_entry;
  assign bus.ras_count     = cnt_q;
  assign bus.ras_overflow  = ovf_q;
  assign bus.ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer: increment, branch wrap, call/return
// nesting, RAS overflow/underflow, stall, restart and reset priority.
module tb_pc_sequencer;
  localparam int WIDTH = 64;
  localparam int DEPTH = 8;
  localparam logic [WIDTH-1:0] RV = 64'h100;

  logic clock;
  logic reset;
  int   n_vec;
  int   n_miss;

  pc_sequencer_if #(.WIDTH(WIDTH), .RAS_DEPTH(DEPTH)) bus ();

  pc_sequencer #(
    .WIDTH(WIDTH), .RAS_DEPTH(DEPTH), .RESET_VECTOR(RV)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic op(input logic [2:0] ps, input logic [63:0] val);
    bus.PS = ps;
    bus.in = val;
    tick();
  endtask

  task automatic chk_state(input string tag, input logic [63:0] pc,
                           input logic [63:0] cnt, input logic [63:0] top);
    chk({tag, ".pc"},  bus.PC, pc);
    chk({tag, ".pc4"}, bus.PC4, pc + 64'd4);
    chk({tag, ".cnt"}, 64'(bus.ras_count), cnt);
    chk({tag, ".top"}, bus.ras_top, top);
  endtask

  initial begin
    logic [63:0] ret;
    n_vec  = 0;
    n_miss = 0;
    reset     = 1'b1;
    bus.stall = 1'b0;
    bus.PS    = 3'b000;
    bus.in    = '0;
    tick();
    tick();
    reset = 1'b0;
    chk_state("reset", 64'h100, 0, 0);
    chk("reset.ovf", 64'(bus.ras_overflow), 0);
    chk("reset.unf", 64'(bus.ras_underflow), 0);

    for (int i = 1; i <= 3; i++) begin
      op(3'b001, '0);
      chk_state($sformatf("inc%0d", i), 64'h100 + 64'(4 * i), 0, 0);
    end

    op(3'b000, 64'h1234);
    chk("hold.pc", bus.PC, 64'h10C);

    op(3'b010, 64'h10);
    chk("jump.pc", bus.PC, 64'h10);
    op(3'b011, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("branch_neg.pc", bus.PC, 64'h10);
    op(3'b011, 64'h3);
    chk("branch_pos.pc", bus.PC, 64'h20);
    op(3'b010, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("jump_top.pc4", bus.PC4, 64'h0);
    op(3'b001, '0);
    chk_state("wrap", 64'h0, 0, 0);

    op(3'b010, 64'h200);
    op(3'b100, 64'h400);
    chk_state("call_abs", 64'h400, 1, 64'h204);
    op(3'b101, 64'h10);
    chk_state("call_rel", 64'h444, 2, 64'h404);
    op(3'b110, '0);
    chk_state("ret1", 64'h404, 1, 64'h204);
    op(3'b110, '0);
    chk_state("ret2", 64'h204, 0, 0);
    chk("ret2.unf", 64'(bus.ras_underflow), 0);

    op(3'b010, 64'h300);
    op(3'b110, '0);
    chk_state("unf1", 64'h304, 0, 0);
    chk("unf1.flag", 64'(bus.ras_underflow), 1);
    op(3'b110, '0);
    chk("unf2.pc", bus.PC, 64'h308);
    chk("unf2.flag", 64'(bus.ras_underflow), 1);
    op(3'b000, '0);
    chk("unf_clr.flag", 64'(bus.ras_underflow), 0);

    op(3'b010, 64'h500);
    for (int k = 0; k <= 8; k++) begin
      ret = (k == 0) ? 64'h504 : 64'h1000 + 64'(16 * (k - 1)) + 64'd4;
      op(3'b100, 64'h1000 + 64'(16 * k));
      chk_state($sformatf("ovf_call%0d", k), 64'h1000 + 64'(16 * k),
                (k < DEPTH) ? 64'(k + 1) : 64'(DEPTH), ret);
      chk($sformatf("ovf_call%0d.flag", k), 64'(bus.ras_overflow), (k == 8) ? 1 : 0);
    end
    op(3'b000, '0);
    chk("ovf_clr.flag", 64'(bus.ras_overflow), 0);
    for (int j = 0; j < DEPTH; j++) begin
      ret = 64'h1000 + 64'(16 * (7 - j)) + 64'd4;
      op(3'b110, '0);
      chk($sformatf("ovf_ret%0d.pc", j), bus.PC, ret);
      chk($sformatf("ovf_ret%0d.cnt", j), 64'(bus.ras_count), 64'(7 - j));
      chk($sformatf("ovf_ret%0d.unf", j), 64'(bus.ras_underflow), 0);
    end
    chk("ovf_ret_last.top", bus.ras_top, 0);

    op(3'b010, 64'h600);
    op(3'b100, 64'h700);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      op(3'b100, 64'h900);
      chk_state($sformatf("stall%0d", i), 64'h700, 1, 64'h604);
      chk($sformatf("stall%0d.ovf", i), 64'(bus.ras_overflow), 0);
    end
    op(3'b111, '0);
    chk_state("stall_restart", 64'h700, 1, 64'h604);
    bus.stall = 1'b0;

    op(3'b111, '0);
    chk_state("restart", 64'h100, 0, 0);

    op(3'b100, 64'h800);
    chk("pre_rst.cnt", 64'(bus.ras_count), 1);
    bus.stall = 1'b1;
    reset     = 1'b1;
    op(3'b100, 64'h900);
    reset     = 1'b0;
    bus.stall = 1'b0;
    chk_state("rst_stall", 64'h100, 0, 0);
    op(3'b110, '0);
    chk("rst_stall_ret.pc", bus.PC, 64'h104);
    chk("rst_stall_ret.unf", 64'(bus.ras_underflow), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the fetch stage: holds the current PC, produces PC+4, and selects the next PC from hold, increment, absolute, or PC-relative targets. It adds a stall input, a reset vector, and a hardware return-address stack (RAS) that supports call and return modes. It sits between the control unit, which drives `PS`, and instruction memory, which is addressed by `PC`.

## Interface
- `WIDTH`, 64: PC and datapath width in bits; must be at least 8.
- `RAS_DEPTH`, 8: number of return-address stack entries; power of two, at least 2.
- `RESET_VECTOR`, 0: PC value loaded on reset and on restart.
- `clock`  in  1: rising-edge clock.
- `reset`  in  1: synchronous, active-high.
- `stall`  in  1: when 1, holds all state; `PS` is ignored.
- `PS`  in  3: next-PC select, decoded below.
- `in`  in  WIDTH: absolute target or signed word offset.
- `PC`  out  WIDTH: current PC, registered.
- `PC4`  out  WIDTH: PC + 4, combinational.
- `ras_top`  out  WIDTH: top-of-stack entry; 0 when the stack is empty.
- `ras_count`  out  $clog2(RAS_DEPTH)+1: number of valid RAS entries.
- `ras_overflow`  out  1: registered one-cycle pulse; a call was made with the stack full.
- `ras_underflow`  out  1: registered one-cycle pulse; a return was made with the stack empty.

## Operation
- Offset: `ofs = {in[WIDTH-3:0], 2'b00}`. The top two bits of `in` are discarded. All additions wrap modulo 2^WIDTH.
- `PS` decode, applied at the rising edge when `stall`=0 and `reset`=0:
  - 000 hold: PC unchanged.
  - 001 increment: PC <= PC4.
  - 010 jump: PC <= in.
  - 011 branch: PC <= PC4 + ofs.
  - 100 call-absolute: push PC4, then PC <= in.
  - 101 call-relative: push PC4, then PC <= PC4 + ofs.
  - 110 return: pop, then PC <= popped value.
  - 111 restart: PC <= RESET_VECTOR, RAS cleared (count 0).
- RAS is a circular buffer with a top pointer and a count. Push writes at top+1 (mod depth) and count increments.
- Push when count == RAS_DEPTH:
  - Overwrites the oldest entry.
  - Count stays at RAS_DEPTH.
  - `ras_overflow`=1 in the next cycle.
  - The PC update still happens.
- Pop when count == 0:
  - PC <= PC4 (fall through).
  - Pointer and count are unchanged.
  - `ras_underflow`=1 in the next cycle.
- Pop with count > 0: returns the top entry; pointer decrements (mod depth) and count decrements.
- Popped entries are not cleared. `ras_top` reports 0 whenever count == 0.
- Stall: PC, RAS contents, pointer and count are held, and both flags are 0 in the following cycle.

## Timing
- Reset (synchronous, takes priority over stall and `PS`):
  - PC = RESET_VECTOR.
  - ras_count = 0, pointer = 0.
  - ras_overflow = ras_underflow = 0.
  - `PC4` = RESET_VECTOR + 4; `ras_top` = 0.
  - RAS contents are not cleared.
- Latency is 1 cycle: a `PS`/`in` value sampled at edge N is visible on `PC` after edge N.
- `PC4` and `ras_top` are combinational from registered state only. No combinational path runs from `PS`, `in` or `stall` to any output.
- Flags are high for exactly one cycle per offending edge. Back-to-back offending operations keep the flag high on consecutive cycles.
- A call directly followed by a return returns that call's PC4; there is no forwarding hazard because the push completes at the edge.
- Reset asserted mid-sequence discards all pending stack state at that edge.
- Restart (111) and reset produce the same PC and count. Restart differs only in being suppressible by `stall`.

## Test plan
- Reset and increment (RESET_VECTOR=0x100): assert reset, then PS=001 for 3 cycles.
  - Required: PC = 0x100, 0x104, 0x108, 0x10C.
  - Required: PC4 = PC+4 throughout; ras_count = 0.
- Branch with negative offset and wrap: PC=0x10, PS=011, in=all-ones (-1).
  - Required: PC = 0x10.
  - Then at PC=0xFFFF_FFFF_FFFF_FFFC with PS=001, required: PC = 0.
- Call/return nesting: at PC=0x200, call-absolute in=0x400; at 0x400, call-relative in=0x10; then return twice.
  - Required after the calls: PC = 0x400, then 0x444; ras_count 1, then 2; ras_top = 0x404.
  - Required after the returns: PC = 0x404, then 0x204; ras_count = 0.
- Overflow (RAS_DEPTH=8): 9 consecutive calls with in=0x1000+16k for k=0..8.
  - Required: ras_overflow pulses exactly once, after the 9th call; ras_count stays 8.
  - Then 8 returns: the oldest return address (first call's PC4) is lost; the 8th return yields the 2nd call's PC4.
- Underflow: with the stack empty at PC=0x300, PS=110.
  - Required: PC = 0x304; ras_underflow = 1 for exactly one cycle; ras_count = 0.
- Stall and reset priority:
  - stall=1 with PS=100 for 3 cycles: PC, ras_count and ras_top are unchanged.
  - reset=1 together with stall=1: PC = RESET_VECTOR and ras_count = 0 after the edge.
